// File: rtl/pll_rstseq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// State encoding, counter width helper and the lock-loss saturation limit.
package pll_rstseq_pkg;

  // Sequencer states, in release order.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    REL_VIDEO = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Saturation value of the optional lock-loss counter.
  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  // Width of the shared phase counter: wide enough to hold the larger of the two
  // terminal counts plus one, so neither phase can alias.
  function automatic int cnt_w(input int stable_cycles, input int release_gap);
    int max_v;
    max_v = (stable_cycles > release_gap) ? stable_cycles : release_gap;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_lock_sync.sv
// lock_sync: multi-stage single-bit synchroniser for the asynchronous PLL lock flag.
// Stage 0 samples the raw input; q is the last stage. Synchronous active-low clear.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift chain: each stage takes the previous one, stage 0 takes the raw flag.
  assign sync_d[0] = d;
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    assign sync_d[gi] = sync_q[gi-1];
  end

  // Synchroniser flops, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: waits for a stable PLL lock, releases video reset, then core
// reset after a programmable gap, drops both on loss of lock, and generates the
// pixel clock-enable for the video timing logic.
// Optional feature: define PLL_RSTSEQ_LOCK_LOSS_CNT_EN to add the saturating
// lock_loss_cnt[7:0] output.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 16,
  parameter int CE_DIV             = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       video_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       ce_pix
`ifdef PLL_RSTSEQ_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  import pll_rstseq_pkg::*;

  localparam int CNT_W = cnt_w(LOCK_STABLE_CYCLES, RELEASE_GAP);
  localparam int CE_W  = $clog2(CE_DIV + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CE_W-1:0]  CE_LAST     = CE_W'(CE_DIV - 1);

  logic             locked_s;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             video_rst_q, video_rst_d;
  logic             core_rst_q,  core_rst_d;
  logic             ready_q,     ready_d;
  logic [CE_W-1:0]  ce_cnt_q,    ce_cnt_d;
  logic             ce_pix_q,    ce_pix_d;

  lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state and shared phase counter. Lock loss is checked first so it wins over
  // any count-complete transition in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = REL_VIDEO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REL_VIDEO: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset outputs decoded from the next state so they change on the transition edge.
  always_comb begin
    video_rst_d = (state_d == WAIT_LOCK) || (state_d == STABLE);
    core_rst_d  = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  // Pixel CE divider: parked at zero around any video reset (current or incoming),
  // so the first pulse lands CE_DIV cycles after video reset falls and no pulse
  // ever coincides with video reset being asserted.
  always_comb begin
    ce_cnt_d = '0;
    ce_pix_d = 1'b0;
    if (!video_rst_q && !video_rst_d) begin
      ce_pix_d = (ce_cnt_q == CE_LAST);
      ce_cnt_d = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + CE_W'(1);
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      video_rst_q <= 1'b1;
      core_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
      ce_cnt_q    <= '0;
      ce_pix_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      video_rst_q <= video_rst_d;
      core_rst_q  <= core_rst_d;
      ready_q     <= ready_d;
      ce_cnt_q    <= ce_cnt_d;
      ce_pix_q    <= ce_pix_d;
    end
  end

  assign video_rst = video_rst_q;
  assign core_rst  = core_rst_q;
  assign ready     = ready_q;
  assign ce_pix    = ce_pix_q;

`ifdef PLL_RSTSEQ_LOCK_LOSS_CNT_EN
  logic       lock_lost;
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // A loss event is any exit to WAIT_LOCK caused by the synced lock going low.
  always_comb begin
    lock_lost  = (state_q != WAIT_LOCK) && !locked_s;
    loss_cnt_d = loss_cnt_q;
    if (lock_lost && (loss_cnt_q != LOSS_CNT_MAX)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  // Saturating loss counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule
